// File: rtl/htfab_cell_tester_pkg.sv
// ---------------------------------------------------------------------------
// htfab_cell_tester_pkg
// Shared definitions for the cell-tester pattern source:
//   - src_e        : 3-bit encoding of the eight pattern generators
//   - SEED_*       : generator reset values
//   - LFSR_TAPS    : feedback taps of the 8-bit LFSR (bits 7,5,4,3)
//   - UI_*         : bit positions of the control fields inside ui_in
//   - word_bank_t  : eight 8-bit words, one per generator, indexed by src_e
// ---------------------------------------------------------------------------
package htfab_cell_tester_pkg;

    typedef enum logic [2:0] {
        SRC_UP     = 3'd0,
        SRC_DOWN   = 3'd1,
        SRC_GRAY   = 3'd2,
        SRC_WALK1  = 3'd3,
        SRC_WALK0  = 3'd4,
        SRC_LFSR   = 3'd5,
        SRC_ALT    = 3'd6,
        SRC_TOGGLE = 3'd7
    } src_e;

    localparam int NUM_GEN = 8;

    // Reset seeds. The Gray seed is for the internal binary counter; the
    // visible Gray word of a zero counter is also zero.
    localparam logic [7:0] SEED_UP     = 8'h00;
    localparam logic [7:0] SEED_DOWN   = 8'h00;
    localparam logic [7:0] SEED_GRAY   = 8'h00;
    localparam logic [7:0] SEED_WALK1  = 8'h01;
    localparam logic [7:0] SEED_WALK0  = 8'hFE;
    localparam logic [7:0] SEED_LFSR   = 8'h01;
    localparam logic [7:0] SEED_ALT    = 8'h55;
    localparam logic [7:0] SEED_TOGGLE = 8'h00;

    // Feedback bit = XOR of state bits 7,5,4,3 (x^8+x^6+x^5+x^4+1, maximal).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // ui_in field layout: [7:5] div, [4] trigger, [3] mode, [2:0] source
    localparam int UI_DIV_LSB  = 5;
    localparam int UI_DIV_W    = 3;
    localparam int UI_TRIG_BIT = 4;
    localparam int UI_MODE_BIT = 3;
    localparam int UI_SRC_LSB  = 0;
    localparam int UI_SRC_W    = 3;

    localparam int PC_W = 7;

    typedef logic [NUM_GEN-1:0][7:0] word_bank_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/htfab_cell_tester_pattern_gen.sv
// ---------------------------------------------------------------------------
// htfab_cell_tester_pattern_gen
// The eight pattern generators. All of them advance together on every
// cycle where step is high, regardless of which one is selected downstream.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (loads the seeds)
//   step       in   advance every generator by one step this cycle
//   cur_words  out  current word of each generator (indexed by src_e)
//   next_words out  word each generator would hold after one step
// ---------------------------------------------------------------------------
module htfab_cell_tester_pattern_gen
    import htfab_cell_tester_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    output word_bank_t cur_words,
    output word_bank_t next_words
);

    logic [7:0] up_q,    up_d,    up_nxt;
    logic [7:0] dn_q,    dn_d,    dn_nxt;
    logic [7:0] gbin_q,  gbin_d,  gbin_nxt;
    logic [7:0] walk1_q, walk1_d, walk1_nxt;
    logic [7:0] walk0_q, walk0_d, walk0_nxt;
    logic [7:0] lfsr_q,  lfsr_d,  lfsr_nxt;
    logic [7:0] alt_q,   alt_d,   alt_nxt;
    logic [7:0] tog_q,   tog_d,   tog_nxt;

    always_comb begin
        up_nxt    = up_q + 8'd1;
        dn_nxt    = dn_q - 8'd1;
        gbin_nxt  = gbin_q + 8'd1;
        walk1_nxt = rotl8(walk1_q);
        walk0_nxt = rotl8(walk0_q);
        lfsr_nxt  = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        alt_nxt   = ~alt_q;
        tog_nxt   = ~tog_q;

        up_d    = step ? up_nxt    : up_q;
        dn_d    = step ? dn_nxt    : dn_q;
        gbin_d  = step ? gbin_nxt  : gbin_q;
        walk1_d = step ? walk1_nxt : walk1_q;
        walk0_d = step ? walk0_nxt : walk0_q;
        lfsr_d  = step ? lfsr_nxt  : lfsr_q;
        alt_d   = step ? alt_nxt   : alt_q;
        tog_d   = step ? tog_nxt   : tog_q;
    end

    always_comb begin
        cur_words             = '0;
        cur_words[SRC_UP]     = up_q;
        cur_words[SRC_DOWN]   = dn_q;
        cur_words[SRC_GRAY]   = bin2gray(gbin_q);
        cur_words[SRC_WALK1]  = walk1_q;
        cur_words[SRC_WALK0]  = walk0_q;
        cur_words[SRC_LFSR]   = lfsr_q;
        cur_words[SRC_ALT]    = alt_q;
        cur_words[SRC_TOGGLE] = tog_q;

        next_words             = '0;
        next_words[SRC_UP]     = up_nxt;
        next_words[SRC_DOWN]   = dn_nxt;
        next_words[SRC_GRAY]   = bin2gray(gbin_nxt);
        next_words[SRC_WALK1]  = walk1_nxt;
        next_words[SRC_WALK0]  = walk0_nxt;
        next_words[SRC_LFSR]   = lfsr_nxt;
        next_words[SRC_ALT]    = alt_nxt;
        next_words[SRC_TOGGLE] = tog_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_q    <= SEED_UP;
            dn_q    <= SEED_DOWN;
            gbin_q  <= SEED_GRAY;
            walk1_q <= SEED_WALK1;
            walk0_q <= SEED_WALK0;
            lfsr_q  <= SEED_LFSR;
            alt_q   <= SEED_ALT;
            tog_q   <= SEED_TOGGLE;
        end else begin
            up_q    <= up_d;
            dn_q    <= dn_d;
            gbin_q  <= gbin_d;
            walk1_q <= walk1_d;
            walk0_q <= walk0_d;
            lfsr_q  <= lfsr_d;
            alt_q   <= alt_d;
            tog_q   <= tog_d;
        end
    end

endmodule

// File: rtl/htfab_cell_tester.sv
// ---------------------------------------------------------------------------
// htfab_cell_tester
// Programmable 8-bit test-pattern source. Eight generators advance either
// on a power-of-two divided tick (mode 0) or once per rising trigger edge
// (mode 1). The selected generator's word is driven on uo_out and the bit
// transitions of the last step on uio_out.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, ACTIVE HIGH despite the name
//   ena      in   ignored
//   ui_in    in   [7:5] div, [4] trigger, [3] mode, [2:0] source
//   uo_out   out  current pattern word (cw)
//   uio_in   in   ignored
//   uio_out  out  transition mask of the last step (ct)
//   uio_oe   out  constant 8'hFF
// ---------------------------------------------------------------------------
module htfab_cell_tester
    import htfab_cell_tester_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic rst;
    assign rst = rst_n;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

    logic [UI_DIV_W-1:0] div;
    logic                trig_in;
    logic                mode;
    src_e                src;

    assign div     = ui_in[UI_DIV_LSB +: UI_DIV_W];
    assign trig_in = ui_in[UI_TRIG_BIT];
    assign mode    = ui_in[UI_MODE_BIT];
    assign src     = src_e'(ui_in[UI_SRC_LSB +: UI_SRC_W]);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] div_mask;
    logic            s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic            tick, rise, step;
    logic [7:0]      cw_q, cw_d, ct_q, ct_d;
    word_bank_t      cur_words, next_words;

    // mask = (1<<div)-1: the low div bits set.
    always_comb begin
        div_mask = '0;
        for (int i = 0; i < PC_W; i++) begin
            div_mask[i] = (3'(i) < div);
        end
    end

    assign tick = ((pc_q & div_mask) == div_mask);
    assign rise = s2_q & ~s3_q;
    assign step = mode ? rise : tick;

    htfab_cell_tester_pattern_gen u_pattern_gen (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .cur_words  (cur_words),
        .next_words (next_words)
    );

    // On a step cw takes the value the generator is moving to, so cw and
    // the generator stay aligned; otherwise cw re-samples the current word,
    // which is what makes a source change appear one clock later.
    always_comb begin
        pc_d = pc_q + 7'd1;
        s1_d = trig_in;
        s2_d = s1_q;
        s3_d = s2_q;
        cw_d = cur_words[src];
        ct_d = ct_q;
        if (step) begin
            cw_d = next_words[src];
            ct_d = cw_q ^ next_words[src];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            cw_q <= 8'h00;
            ct_q <= 8'h00;
        end else begin
            pc_q <= pc_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            cw_q <= cw_d;
            ct_q <= ct_d;
        end
    end

    assign uo_out  = cw_q;
    assign uio_out = ct_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_htfab_cell_tester.sv
// ---------------------------------------------------------------------------
// tb_htfab_cell_tester
// Directed bench for htfab_cell_tester. Expected {cw, ct} pairs are pushed
// to exp_q before the clock edge that should produce them and popped and
// compared 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_htfab_cell_tester;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    htfab_cell_tester dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];   // {expected cw, expected ct}

    logic [2:0] div_r;
    logic       trig_r;
    logic       mode_r;
    logic [2:0] src_r;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_ctrl();
        ui_in = {div_r, trig_r, mode_r, src_r};
    endtask

    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clk_and_check(input string tag);
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=no expectation queued expected=one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check8({tag, "_cw"}, uo_out, e[15:8]);
            check8({tag, "_ct"}, uio_out, e[7:0]);
        end
    endtask

    task automatic do_reset(input logic [2:0] div, input logic mode, input logic [2:0] src);
        div_r  = div;
        mode_r = mode;
        src_r  = src;
        trig_r = 1'b0;
        apply_ctrl();
        rst_n = 1'b1;
        exp_q.push_back(16'h0000);
        clk_and_check("reset_a");
        exp_q.push_back(16'h0000);
        clk_and_check("reset_b");
        check8("reset_oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
    endtask

    function automatic logic [7:0] lfsr_ref(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] rotl_ref(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] w, nw, cw_m, ct_m;
        int         gap;

        rst_n  = 1'b1;
        ena    = 1'b1;
        uio_in = 8'($urandom_range(0, 255));
        ui_in  = 8'h00;

        // Up counter, tick every clock.
        do_reset(3'd0, 1'b0, 3'd0);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0203);
        exp_q.push_back(16'h0301);
        exp_q.push_back(16'h0407);
        for (int i = 0; i < 4; i++) clk_and_check("up_div0");

        // Walking one at div=2: a step on edges 3,7,11,...; wraps 0x80 -> 0x01.
        do_reset(3'd2, 1'b0, 3'd3);
        w    = 8'h01;
        ct_m = 8'h00;
        for (int k = 0; k < 36; k++) begin
            if ((k & 3) == 3) begin
                nw   = rotl_ref(w);
                ct_m = w ^ nw;
                w    = nw;
            end
            exp_q.push_back({w, ct_m});
            clk_and_check("walk1_div2");
            if (k == 31) check8("walk1_wrap_ct", uio_out, 8'h81);
        end

        // LFSR stepping every clock: 0x02,0x04,0x08,... period 255, never 0.
        do_reset(3'd0, 1'b0, 3'd5);
        w    = 8'h01;
        cw_m = 8'h00;
        for (int k = 0; k < 258; k++) begin
            nw   = lfsr_ref(w);
            ct_m = cw_m ^ nw;
            cw_m = nw;
            w    = nw;
            exp_q.push_back({cw_m, ct_m});
            clk_and_check("lfsr");
            checks++;
            assert (uo_out !== 8'h00) else begin
                errors++;
                $error("FAIL lfsr_nonzero: observed=%02h expected=nonzero", uo_out);
            end
            if (k == 2) check8("lfsr_third", uo_out, 8'h08);
            if (k == 255) check8("lfsr_period", uo_out, 8'h02);
        end

        // Trigger mode: one step per rising edge, two edges of sync latency.
        do_reset(3'd0, 1'b1, 3'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        clk_and_check("trig_idle");
        clk_and_check("trig_idle");
        trig_r = 1'b1;
        apply_ctrl();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0101);
        for (int i = 0; i < 7; i++) exp_q.push_back(16'h0101);
        for (int i = 0; i < 10; i++) clk_and_check("trig_hold");
        trig_r = 1'b0;
        apply_ctrl();
        gap = $urandom_range(2, 4);
        for (int i = 0; i < gap; i++) begin
            exp_q.push_back(16'h0101);
            clk_and_check("trig_low");
        end
        trig_r = 1'b1;
        apply_ctrl();
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0101);
        exp_q.push_back(16'h0203);
        exp_q.push_back(16'h0203);
        for (int i = 0; i < 4; i++) clk_and_check("trig_second");
        trig_r = 1'b0;
        apply_ctrl();

        // div=7, alternating source, switched to toggle after the first tick.
        do_reset(3'd7, 1'b0, 3'd6);
        exp_q.push_back(16'h5500);
        clk_and_check("alt_e0");
        run_edges(125);
        exp_q.push_back(16'h5500);
        clk_and_check("alt_e126");
        exp_q.push_back(16'hAAFF);
        clk_and_check("alt_e127");
        src_r = 3'd7;
        apply_ctrl();
        exp_q.push_back(16'hFFFF);
        clk_and_check("switch_e128");
        run_edges(126);
        exp_q.push_back(16'h00FF);
        clk_and_check("tog_e255");
        exp_q.push_back(16'h00FF);
        clk_and_check("tog_e256");

        // Back to alternating, then reset in the middle of the count.
        src_r = 3'd6;
        apply_ctrl();
        exp_q.push_back(16'h55FF);
        clk_and_check("alt_e257");
        rst_n = 1'b1;
        exp_q.push_back(16'h0000);
        clk_and_check("mid_reset");
        rst_n = 1'b0;
        exp_q.push_back(16'h5500);
        clk_and_check("post_e0");
        run_edges(125);
        exp_q.push_back(16'h5500);
        clk_and_check("post_e126");
        exp_q.push_back(16'hAAFF);
        clk_and_check("post_e127");

        // ---------------- final report ----------------
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
